// File: rtl/core_pkg.sv
// Shared constants for the core sequencer: opcodes, instruction field positions,
// FSM state encodings and decoded op classes.
package core_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'd10;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_BEQZ = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int RD_MSB   = 27;
  localparam int RD_LSB   = 23;
  localparam int RA_MSB   = 22;
  localparam int RA_LSB   = 18;
  localparam int RB_MSB   = 17;
  localparam int RB_LSB   = 13;
  localparam int FUNC_MSB = 3;
  localparam int FUNC_LSB = 0;
  localparam int TGT_MSB  = 15;
  localparam int TGT_LSB  = 0;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_BEQZ,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [3:0]  func;
    logic [15:0] target;
  } fields_t;

endpackage

// File: rtl/core_seq_decode.sv
// Combinational instruction decode: op class, illegal flag and field extraction.
// Opcode 2 (BEQZ) is legal only when CORE_SEQ_BRANCH_EN is defined.
module core_seq_decode
  import core_pkg::*;
(
  input  logic [31:0] ir,
  output op_class_t   op_class,
  output logic        illegal,
  output fields_t     fields
);

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (ir[OP_MSB:OP_LSB])
      OP_NOP:  op_class = CLS_NOP;
      OP_ALU:  op_class = CLS_ALU;
`ifdef CORE_SEQ_BRANCH_EN
      OP_BEQZ: op_class = CLS_BEQZ;
`endif
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

  assign illegal       = (op_class == CLS_ILLEGAL);
  assign fields.rd     = ir[RD_MSB:RD_LSB];
  assign fields.ra     = ir[RA_MSB:RA_LSB];
  assign fields.rb     = ir[RB_MSB:RB_LSB];
  assign fields.func   = ir[FUNC_MSB:FUNC_LSB];
  assign fields.target = ir[TGT_MSB:TGT_LSB];

endmodule

// File: rtl/core_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB instruction sequencer owning pc and halt status.
// Optional feature: CORE_SEQ_BRANCH_EN enables BEQZ; otherwise opcode 2 is illegal.
module core_seq
  import core_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_read_addr_a,
  output logic [4:0]  rf_read_addr_b,
  input  logic [31:0] rf_read_data_a,
  input  logic [31:0] rf_read_data_b,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        rf_write_enable,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [3:0]  alu_func,
  output logic        alu_clk_en,
  input  logic [31:0] alu_result,
  output logic [15:0] pc,
  output logic        retire,
  output logic        halted,
  output logic        illegal
);

  logic [2:0]  state;
  logic [31:0] ir;
  op_class_t   op_class;
  logic        dec_illegal;
  fields_t     fields;
  logic        run;

  core_seq_decode u_decode (
    .ir       (ir),
    .op_class (op_class),
    .illegal  (dec_illegal),
    .fields   (fields)
  );

  // Strobes are suppressed both while frozen and on a reset cycle.
  assign run = clk_en & ~rst;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_FETCH;
      pc            <= RESET_PC;
      ir            <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_func      <= '0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
    end else if (clk_en) begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (op_class)
            CLS_ALU: begin
              alu_operand_a <= rf_read_data_a;
              alu_operand_b <= rf_read_data_b;
              alu_func      <= fields.func;
              state         <= ST_EXEC;
            end
            CLS_NOP: begin
              pc    <= pc + 16'd1;
              state <= ST_FETCH;
            end
            CLS_BEQZ: begin
              pc    <= (rf_read_data_a == 32'd0) ? fields.target : pc + 16'd1;
              state <= ST_FETCH;
            end
            CLS_HALT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: begin
              halted  <= 1'b1;
              illegal <= dec_illegal;
              state   <= ST_HALT;
            end
          endcase
        end
        ST_EXEC: state <= ST_WB;
        ST_WB: begin
          pc    <= pc + 16'd1;
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

  assign imem_req        = run && (state == ST_FETCH);
  assign imem_addr       = pc;
  assign rf_read_addr_a  = fields.ra;
  assign rf_read_addr_b  = fields.rb;
  assign alu_clk_en      = run && (state == ST_EXEC);
  assign rf_write_enable = run && (state == ST_WB);
  assign rf_write_addr   = fields.rd;
  assign rf_write_data   = (state == ST_WB) ? alu_result : 32'd0;

  // Short ops retire out of DECODE; ALU ops retire on their write-back.
  assign retire = run && ((state == ST_WB) ||
                  ((state == ST_DECODE) && ((op_class == CLS_NOP) || (op_class == CLS_BEQZ))));

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq with behavioural imem, regfile and ALU.
// BEQZ expectations follow CORE_SEQ_BRANCH_EN.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  rf_read_addr_a, rf_read_addr_b, rf_write_addr;
  logic [31:0] rf_read_data_a, rf_read_data_b, rf_write_data;
  logic        rf_write_enable;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0]  alu_func;
  logic        alu_clk_en;
  logic [15:0] pc;
  logic        retire, halted, illegal;

  // Second instance starting at 16'hFFFF, fed only NOPs, for the pc wrap case.
  logic        w_req, w_we, w_alu_en, w_retire, w_halted, w_illegal;
  logic [15:0] w_addr, w_pc;
  logic [4:0]  w_ra, w_rb, w_wa;
  logic [31:0] w_wd, w_oa, w_ob;
  logic [3:0]  w_func;

  logic [31:0] imem [65536];
  logic [31:0] regs [32];
  logic [31:0] r4_init = 32'd0;
  int          ack_delay = 0;
  int          wait_cnt;
  int          alu_pulses;
  int          req_cycles;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  core_seq dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
    .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_func(alu_func),
    .alu_clk_en(alu_clk_en), .alu_result(alu_result),
    .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
  );

  core_seq #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(32'd0),
    .rf_read_addr_a(w_ra), .rf_read_addr_b(w_rb),
    .rf_read_data_a(32'd0), .rf_read_data_b(32'd0),
    .rf_write_addr(w_wa), .rf_write_data(w_wd), .rf_write_enable(w_we),
    .alu_operand_a(w_oa), .alu_operand_b(w_ob), .alu_func(w_func),
    .alu_clk_en(w_alu_en), .alu_result(32'd0),
    .pc(w_pc), .retire(w_retire), .halted(w_halted), .illegal(w_illegal)
  );

  assign imem_ack       = imem_req && (wait_cnt >= ack_delay);
  assign imem_rdata     = imem[imem_addr];
  assign rf_read_data_a = regs[rf_read_addr_a];
  assign rf_read_data_b = regs[rf_read_addr_b];

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[1] <= 32'd7;
      regs[2] <= 32'd5;
      regs[4] <= r4_init;
    end else if (rf_write_enable) begin
      regs[rf_write_addr] <= rf_write_data;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      alu_result <= 32'd0;
      alu_pulses <= 0;
      req_cycles <= 0;
    end else begin
      if (alu_clk_en) begin
        alu_result <= (alu_func == 4'd0) ? alu_operand_a + alu_operand_b
                                         : alu_operand_a - alu_operand_b;
        alu_pulses <= alu_pulses + 1;
      end
      if (imem_req) req_cycles <= req_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: first cycle after reset, before its closing edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] enc_alu(input logic [4:0] rd, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [3:0] func);
    return {4'h1, rd, ra, rb, 9'd0, func};
  endfunction

  function automatic logic [31:0] enc_beqz(input logic [4:0] ra, input logic [15:0] tgt);
    return {4'h2, 5'd0, ra, 2'd0, tgt};
  endfunction

  initial begin
    // ALU op followed by HALT, zero-wait memory.
    imem[10] = enc_alu(5'd3, 5'd1, 5'd2, 4'd0);
    imem[11] = 32'hF000_0000;
    do_reset();
    check("c0_req", 32'(imem_req), 1);
    check("c0_addr", 32'(imem_addr), 10);
    check("c0_pc", 32'(pc), 10);
    check("c0_strobes", {28'd0, retire, halted, illegal, rf_write_enable}, 0);
    check("c0_alu_en", 32'(alu_clk_en), 0);
    check("c0_operand", alu_operand_a, 0);
    check("wrap_c0_pc", 32'(w_pc), 32'hFFFF);
    step();
    check("c1_req", 32'(imem_req), 0);
    check("c1_alu_en", 32'(alu_clk_en), 0);
    check("wrap_c1_retire", 32'(w_retire), 1);
    step();
    check("c2_alu_en", 32'(alu_clk_en), 1);
    check("c2_op_a", alu_operand_a, 7);
    check("c2_op_b", alu_operand_b, 5);
    check("c2_func", 32'(alu_func), 0);
    check("c2_we", 32'(rf_write_enable), 0);
    check("wrap_c2_pc", 32'(w_pc), 0);
    step();
    check("c3_we", 32'(rf_write_enable), 1);
    check("c3_waddr", 32'(rf_write_addr), 3);
    check("c3_wdata", rf_write_data, 12);
    check("c3_retire", 32'(retire), 1);
    check("c3_alu_en", 32'(alu_clk_en), 0);
    step();
    check("c4_pc", 32'(pc), 11);
    check("c4_addr", 32'(imem_addr), 11);
    check("c4_retire", 32'(retire), 0);
    check("r3_written", regs[3], 12);
    step();
    step();
    check("halt_halted", 32'(halted), 1);
    check("halt_not_illegal", 32'(illegal), 0);
    check("halt_pc", 32'(pc), 11);
    check("halt_no_req", 32'(imem_req), 0);

    // Fetch acknowledged only after three wait cycles.
    imem[10] = 32'h0000_0000;
    ack_delay = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("wait_req", 32'(imem_req), 1);
      check("wait_addr", 32'(imem_addr), 10);
      check("wait_ack", 32'(imem_ack), 0);
      check("wait_strobes", {29'd0, retire, alu_clk_en, rf_write_enable}, 0);
      step();
    end
    check("wait_ack_seen", 32'(imem_ack), 1);
    step();
    check("wait_nop_retire", 32'(retire), 1);
    step();
    check("wait_nop_pc", 32'(pc), 11);
    ack_delay = 0;

    // clk_en dropped for two cycles while in EXEC.
    imem[10] = enc_alu(5'd5, 5'd1, 5'd2, 4'd1);
    do_reset();
    step();
    step();
    clk_en = 1'b0;
    #1;
    check("frz0_alu_en", 32'(alu_clk_en), 0);
    step();
    check("frz1_alu_en", 32'(alu_clk_en), 0);
    check("frz1_we", 32'(rf_write_enable), 0);
    step();
    clk_en = 1'b1;
    #1;
    check("frz_resume_alu_en", 32'(alu_clk_en), 1);
    step();
    check("frz_wb_we", 32'(rf_write_enable), 1);
    check("frz_wb_addr", 32'(rf_write_addr), 5);
    check("frz_wb_data", rf_write_data, 2);
    check("frz_wb_retire", 32'(retire), 1);
    step();
    check("frz_pulses", 32'(alu_pulses), 1);
    check("frz_r5", regs[5], 2);
    check("frz_pc", 32'(pc), 11);

    // Illegal opcode 7.
    imem[10] = 32'h7000_0000;
    do_reset();
    step();
    check("ill_decode_retire", 32'(retire), 0);
    step();
    check("ill_halted", 32'(halted), 1);
    check("ill_illegal", 32'(illegal), 1);
    check("ill_pc", 32'(pc), 10);
    for (int i = 0; i < 5; i++) step();
    check("ill_req_cycles", 32'(req_cycles), 1);

    // Opcode 2: branch when enabled, illegal otherwise.
    imem[10] = enc_beqz(5'd4, 16'h0040);
    r4_init = 32'd0;
    do_reset();
    step();
`ifdef CORE_SEQ_BRANCH_EN
    check("beqz_taken_retire", 32'(retire), 1);
    step();
    check("beqz_taken_pc", 32'(pc), 32'h40);
    check("beqz_taken_addr", 32'(imem_addr), 32'h40);
    r4_init = 32'd5;
    do_reset();
    step();
    step();
    check("beqz_fall_pc", 32'(pc), 11);
    check("beqz_fall_halted", 32'(halted), 0);
`else
    check("op2_retire", 32'(retire), 0);
    step();
    check("op2_halted", 32'(halted), 1);
    check("op2_illegal", 32'(illegal), 1);
    check("op2_pc", 32'(pc), 10);
`endif

    // Reset asserted in WB suppresses the write.
    imem[10] = enc_alu(5'd6, 5'd1, 5'd2, 4'd0);
    do_reset();
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("rstwb_we", 32'(rf_write_enable), 0);
    check("rstwb_retire", 32'(retire), 0);
    step();
    rst = 1'b0;
    #1;
    check("rstwb_pc", 32'(pc), 10);
    check("rstwb_r6", regs[6], 0);
    check("rstwb_req", 32'(imem_req), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
